// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: opcode and condition encodings, NZCV bit positions,
// and the helper that says which opcodes write their destination register.
package cpu_defs_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_ORR = 4'b0011;
    localparam logic [3:0] OP_EOR = 4'b0100;
    localparam logic [3:0] OP_MOV = 4'b0101;
    localparam logic [3:0] OP_LSL = 4'b0110;
    localparam logic [3:0] OP_LSR = 4'b0111;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // ALU ops 0000-0111 and LDR produce a register result; CMP/STR/others do not.
    function automatic logic writes_rd(input logic [3:0] opcode);
        return (opcode[3] == 1'b0) || (opcode == OP_LDR);
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition code against NZCV flags.
module cond_check
    import cpu_defs_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c & !z;
            COND_LS: pass = !c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_writeback_stage.sv
// Post-ALU stage: condition evaluation, NZCV ownership, retire/skip statistics,
// and a 2-entry in-order writeback buffer toward the register file.
module exec_writeback_stage
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic [REG_AW-1:0] in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        nzcv,
    output logic [CNT_W-1:0]  cnt_exec,
    output logic [CNT_W-1:0]  cnt_skip
);

    // Handshakes: a beat transfers on an edge where valid & ready are both high.
    // in_ready depends only on buffer occupancy; flush blocks acceptance.

    logic [1:0]        count;
    logic [REG_AW-1:0] rd1;
    logic [DATA_W-1:0] data1;
    logic              pass;
    logic              accept;
    logic              push;
    logic              pop;

    cond_check u_cond_check (
        .cond (in_cond),
        .nzcv (nzcv),
        .pass (pass)
    );

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign push      = accept & pass & writes_rd(in_opcode);
    assign pop       = out_valid & out_ready;

    // Slot 0 is the head and drives out_* directly, so it simply holds when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            out_rd   <= '0;
            out_data <= '0;
            rd1      <= '0;
            data1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (push && pop) begin
            if (count == 2'd1) begin
                out_rd   <= in_rd;
                out_data <= in_result;
            end else begin
                out_rd   <= rd1;
                out_data <= data1;
                rd1      <= in_rd;
                data1    <= in_result;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                out_rd   <= in_rd;
                out_data <= in_result;
            end else begin
                rd1   <= in_rd;
                data1 <= in_result;
            end
            count <= count + 2'd1;
        end else if (pop) begin
            if (count == 2'd2) begin
                out_rd   <= rd1;
                out_data <= data1;
            end
            count <= count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv     <= 4'b0000;
            cnt_exec <= '0;
            cnt_skip <= '0;
        end else if (accept) begin
            if (pass) begin
                cnt_exec <= cnt_exec + CNT_W'(1);
                if (in_s || (in_opcode == OP_CMP)) begin
                    nzcv <= in_flags;
                end
            end else begin
                cnt_skip <= cnt_skip + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Directed bench for exec_writeback_stage: hand-computed expectations per scenario.
module tb_exec_writeback_stage;
    import cpu_defs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [3:0]  in_flags;
    logic [3:0]  in_opcode;
    logic [3:0]  in_cond;
    logic        in_s;
    logic [3:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rd;
    logic [31:0] out_data;
    logic [3:0]  nzcv;
    logic [15:0] cnt_exec;
    logic [15:0] cnt_skip;

    int n_vec;
    int n_err;

    exec_writeback_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_flags  (in_flags),
        .in_opcode (in_opcode),
        .in_cond   (in_cond),
        .in_s      (in_s),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .nzcv      (nzcv),
        .cnt_exec  (cnt_exec),
        .cnt_skip  (cnt_skip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] cond, input logic s,
                         input logic [3:0] flags, input logic [3:0] rd, input logic [31:0] res);
        in_valid  = 1'b1;
        in_opcode = op;
        in_cond   = cond;
        in_s      = s;
        in_flags  = flags;
        in_rd     = rd;
        in_result = res;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; in_result = '0; in_flags = '0; in_opcode = '0;
        in_cond = '0; in_s = 1'b0; in_rd = '0;
        #2;
        n_vec++; if (nzcv !== 4'b0000) begin n_err++; $display("FAIL reset_nzcv got %b exp %b", nzcv, 4'b0000); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_vec++; if (out_rd !== 4'd0) begin n_err++; $display("FAIL reset_out_rd got %0d exp 0", out_rd); end
        n_vec++; if (out_data !== 32'd0) begin n_err++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        n_vec++; if (cnt_exec !== 16'd0) begin n_err++; $display("FAIL reset_cnt_exec got %0d exp 0", cnt_exec); end
        n_vec++; if (cnt_skip !== 16'd0) begin n_err++; $display("FAIL reset_cnt_skip got %0d exp 0", cnt_skip); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        drive(OP_ADD, COND_AL, 1'b0, 4'b1111, 4'd3, 32'h0000_0005);
        step();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        n_vec++; if (out_rd !== 4'd3) begin n_err++; $display("FAIL basic_rd got %0d exp 3", out_rd); end
        n_vec++; if (out_data !== 32'h5) begin n_err++; $display("FAIL basic_data got %h exp 5", out_data); end
        n_vec++; if (nzcv !== 4'b0000) begin n_err++; $display("FAIL basic_nzcv got %b exp 0000", nzcv); end
        n_vec++; if (cnt_exec !== 16'd1) begin n_err++; $display("FAIL basic_cnt_exec got %0d exp 1", cnt_exec); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b exp 0", out_valid); end
        n_vec++; if (out_data !== 32'h5) begin n_err++; $display("FAIL basic_hold_empty got %h exp 5", out_data); end
    endtask

    task automatic test_cond();
        drive(OP_CMP, COND_AL, 1'b0, 4'b0100, 4'd7, 32'd99);
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL cmp_no_wb got %b exp 0", out_valid); end
        n_vec++; if (nzcv !== 4'b0100) begin n_err++; $display("FAIL cmp_nzcv got %b exp 0100", nzcv); end
        drive(OP_SUB, COND_EQ, 1'b0, 4'b0000, 4'd2, 32'h10);
        step();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub_eq_valid got %b exp 1", out_valid); end
        n_vec++; if (out_rd !== 4'd2) begin n_err++; $display("FAIL sub_eq_rd got %0d exp 2", out_rd); end
        n_vec++; if (out_data !== 32'h10) begin n_err++; $display("FAIL sub_eq_data got %h exp 10", out_data); end
        n_vec++; if (cnt_exec !== 16'd3) begin n_err++; $display("FAIL sub_eq_cnt got %0d exp 3", cnt_exec); end
        drive(OP_SUB, COND_NE, 1'b0, 4'b0000, 4'd4, 32'h20);
        step();
        n_vec++; if (cnt_skip !== 16'd1) begin n_err++; $display("FAIL sub_ne_skip got %0d exp 1", cnt_skip); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_ne_no_wb got %b exp 0", out_valid); end
        n_vec++; if (out_data !== 32'h10) begin n_err++; $display("FAIL sub_ne_hold got %h exp 10", out_data); end
        // S-bit update then immediate use of the new flags.
        drive(OP_ADD, COND_AL, 1'b1, 4'b1000, 4'd1, 32'hA);
        step();
        n_vec++; if (nzcv !== 4'b1000) begin n_err++; $display("FAIL s_nzcv got %b exp 1000", nzcv); end
        drive(OP_ADD, COND_LT, 1'b0, 4'b0000, 4'd5, 32'hB);
        step();
        n_vec++; if (out_data !== 32'hB) begin n_err++; $display("FAIL fwd_lt_data got %h exp b", out_data); end
        n_vec++; if (out_rd !== 4'd5) begin n_err++; $display("FAIL fwd_lt_rd got %0d exp 5", out_rd); end
        drive(OP_ADD, COND_GE, 1'b0, 4'b0000, 4'd6, 32'hC);
        step();
        n_vec++; if (cnt_skip !== 16'd2) begin n_err++; $display("FAIL fwd_ge_skip got %0d exp 2", cnt_skip); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fwd_ge_no_wb got %b exp 0", out_valid); end
        drive(OP_STR, COND_AL, 1'b0, 4'b0000, 4'd8, 32'h77);
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL str_no_wb got %b exp 0", out_valid); end
        drive(OP_LDR, COND_AL, 1'b0, 4'b0000, 4'd9, 32'hDEAD);
        step();
        idle();
        n_vec++; if (out_data !== 32'hDEAD) begin n_err++; $display("FAIL ldr_data got %h exp dead", out_data); end
        n_vec++; if (out_rd !== 4'd9) begin n_err++; $display("FAIL ldr_rd got %0d exp 9", out_rd); end
        step();
        n_vec++; if (cnt_exec !== 16'd7) begin n_err++; $display("FAIL cond_cnt_exec got %0d exp 7", cnt_exec); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(OP_ADD, COND_AL, 1'b0, 4'b0000, 4'd1, 32'h111);
        step();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        drive(OP_ADD, COND_AL, 1'b0, 4'b0000, 4'd2, 32'h222);
        step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        drive(OP_ADD, COND_AL, 1'b0, 4'b0000, 4'd3, 32'h333);
        step();
        step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
        n_vec++; if (out_data !== 32'h111) begin n_err++; $display("FAIL bp_hold got %h exp 111", out_data); end
        n_vec++; if (cnt_exec !== 16'd9) begin n_err++; $display("FAIL bp_cnt_wait got %0d exp 9", cnt_exec); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_data !== 32'h222) begin n_err++; $display("FAIL bp_order2 got %h exp 222", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_again got %b exp 1", in_ready); end
        step();
        idle();
        n_vec++; if (out_data !== 32'h333) begin n_err++; $display("FAIL bp_order3 got %h exp 333", out_data); end
        n_vec++; if (out_rd !== 4'd3) begin n_err++; $display("FAIL bp_order3_rd got %0d exp 3", out_rd); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
        n_vec++; if (cnt_exec !== 16'd10) begin n_err++; $display("FAIL bp_cnt got %0d exp 10", cnt_exec); end
    endtask

    task automatic test_back_to_back();
        drive(OP_ORR, COND_AL, 1'b0, 4'b0000, 4'd6, 32'h444);
        step();
        drive(OP_EOR, COND_AL, 1'b0, 4'b0000, 4'd7, 32'h555);
        step();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b exp 1", out_valid); end
        n_vec++; if (out_rd !== 4'd7) begin n_err++; $display("FAIL b2b_rd got %0d exp 7", out_rd); end
        n_vec++; if (out_data !== 32'h555) begin n_err++; $display("FAIL b2b_data got %h exp 555", out_data); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
        step();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_occ1 got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(OP_MOV, COND_AL, 1'b0, 4'b0000, 4'd1, 32'h666);
        step();
        drive(OP_MOV, COND_AL, 1'b0, 4'b0000, 4'd2, 32'h777);
        step();
        drive(OP_ADD, COND_AL, 1'b1, 4'b0000, 4'd8, 32'h888);
        flush = 1'b1;
        step();
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid got %b exp 0", out_valid); end
        n_vec++; if (nzcv !== 4'b1000) begin n_err++; $display("FAIL flush_full_nzcv got %b exp 1000", nzcv); end
        n_vec++; if (cnt_exec !== 16'd14) begin n_err++; $display("FAIL flush_full_cnt got %0d exp 14", cnt_exec); end
        drive(OP_MOV, COND_AL, 1'b0, 4'b0000, 4'd4, 32'h999);
        step();
        drive(OP_ADD, COND_AL, 1'b1, 4'b0011, 4'd5, 32'hAAA);
        flush = 1'b1;
        step();
        idle();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_beat_valid got %b exp 0", out_valid); end
        n_vec++; if (nzcv !== 4'b1000) begin n_err++; $display("FAIL flush_beat_nzcv got %b exp 1000", nzcv); end
        n_vec++; if (cnt_exec !== 16'd15) begin n_err++; $display("FAIL flush_beat_cnt got %0d exp 15", cnt_exec); end
        n_vec++; if (out_data !== 32'h999) begin n_err++; $display("FAIL flush_hold got %h exp 999", out_data); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        drive(OP_ADD, COND_NV, 1'b0, 4'b0000, 4'd1, 32'h1);
        repeat (65533) @(posedge clk);
        #1;
        n_vec++; if (cnt_skip !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got %h exp ffff", cnt_skip); end
        step();
        idle();
        n_vec++; if (cnt_skip !== 16'h0000) begin n_err++; $display("FAIL wrap_zero got %h exp 0000", cnt_skip); end
        n_vec++; if (cnt_exec !== 16'd15) begin n_err++; $display("FAIL wrap_exec got %0d exp 15", cnt_exec); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_no_wb got %b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(OP_ADD, COND_AL, 1'b1, 4'b0110, 4'd3, 32'h1234);
        step();
        idle();
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_pre_valid got %b exp 1", out_valid); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_vec++; if (nzcv !== 4'b0000) begin n_err++; $display("FAIL arst_nzcv got %b exp 0000", nzcv); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", out_valid); end
        n_vec++; if (out_rd !== 4'd0) begin n_err++; $display("FAIL arst_rd got %0d exp 0", out_rd); end
        n_vec++; if (out_data !== 32'd0) begin n_err++; $display("FAIL arst_data got %h exp 0", out_data); end
        n_vec++; if (cnt_exec !== 16'd0) begin n_err++; $display("FAIL arst_cnt_exec got %0d exp 0", cnt_exec); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %b exp 1", in_ready); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_cond();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
